ssf_out_fifo: RTL and testbench

SSF_OUT_FIFO -- requirements
Module: ssf_out_fifo

---
 rtl/ssf_out_fifo.sv | 96 +++++++++
 tb/tb_ssf_out_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ssf_out_fifo.sv
// Output FIFO for the ssf array: captures strobed filter results and presents them
// first-word-fall-through, counting results dropped while the FIFO is full.
module ssf_out_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [DW-1:0]      io_out,
  input  logic [1:0]                out_en,
  input  logic                      clr_ovf,
  output logic signed [DW-1:0]      rd_data,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow,
  output logic [7:0]                drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic          push_req, pop, push_ok, drop;

  // Handshake decode and next-state; a full FIFO still accepts when it pops the same cycle
  always_comb begin
    push_req   = 1'b0;
    pop        = 1'b0;
    push_ok    = 1'b0;
    drop       = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    push_req = (out_en == 2'd1);
    pop      = (count_q != '0) && rd_ready;
    push_ok  = push_req && ((count_q < CW'(DEPTH)) || pop);
    drop     = push_req && !push_ok;

    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);

    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);

    // A drop in the same cycle as a clear leaves exactly one recorded drop
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_ovf)                  drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is not reset; validity comes from count alone
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= io_out;
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign rd_valid = !empty;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_ssf_out_fifo.sv
// Testbench for ssf_out_fifo: directed scenarios plus randomized traffic against a
// queue-based reference model.
module tb_ssf_out_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [DW-1:0] io_out = '0;
  logic [1:0]           out_en = 2'd0;
  logic                 clr_ovf = 1'b0;
  logic signed [DW-1:0] rd_data;
  logic                 rd_valid;
  logic                 rd_ready = 1'b0;
  logic [4:0]           count;
  logic                 full, empty, overflow;
  logic [7:0]           drop_cnt;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mq[$];
  logic          mo = 1'b0;
  int            md = 0;

  ssf_out_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .io_out(io_out), .out_en(out_en), .clr_ovf(clr_ovf),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .count(count),
    .full(full), .empty(empty), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Drive one clock cycle and advance the reference model by the FIFO rules
  task automatic do_cycle(input logic [1:0] en, input logic [DW-1:0] d,
                          input logic rdy, input logic clr);
    bit pop_m, acc, req;
    out_en = en; io_out = d; rd_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    req   = (en == 2'd1);
    pop_m = (mq.size() > 0) && rdy;
    acc   = req && ((mq.size() < DEPTH) || pop_m);
    if (pop_m) void'(mq.pop_front());
    if (acc) mq.push_back(d);
    if (req && !acc) begin
      mo = 1'b1;
      md = clr ? 1 : ((md < 255) ? md + 1 : 255);
    end else if (clr) begin
      mo = 1'b0;
      md = 0;
    end
    #1;
    out_en = 2'd0; rd_ready = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0 || rd_valid !== 1'b0) begin
      failures++; $display("FAIL reset_flags got empty=%b full=%b valid=%b exp 1 0 0", empty, full, rd_valid); end
    checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      failures++; $display("FAIL reset_ovf got ovf=%b drop=%0d exp 0 0", overflow, drop_cnt); end
    rst = 1'b0;
    mq.delete(); mo = 1'b0; md = 0;
  endtask

  task automatic test_single_word();
    out_en = 2'd1; io_out = -5; #1;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL no_bypass got=%b exp=0", rd_valid); end
    do_cycle(2'd1, -32'sd5, 1'b0, 1'b0);
    checks++; if (rd_valid !== 1'b1 || rd_data !== -32'sd5 || count !== 5'd1) begin
      failures++; $display("FAIL single_word got valid=%b data=%0d count=%0d exp 1 -5 1", rd_valid, rd_data, count); end
    do_cycle(2'd0, '0, 1'b1, 1'b0);
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL single_drain got empty=%b exp=1", empty); end
  endtask

  task automatic test_strobe_filter();
    logic [1:0] ens[3] = '{2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 3; i++) begin
      do_cycle(ens[i], $urandom, 1'b0, 1'b0);
      checks++; if (count !== 5'd0 || rd_valid !== 1'b0) begin
        failures++; $display("FAIL strobe_filter en=%0d got count=%0d valid=%b exp 0 0", ens[i], count, rd_valid); end
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 18; i++) do_cycle(2'd1, DW'(i), 1'b0, 1'b0);
    checks++; if (full !== 1'b1 || count !== 5'd16) begin
      failures++; $display("FAIL fill_full got full=%b count=%0d exp 1 16", full, count); end
    checks++; if (overflow !== 1'b1 || drop_cnt !== 8'd2) begin
      failures++; $display("FAIL fill_ovf got ovf=%b drop=%0d exp 1 2", overflow, drop_cnt); end
    for (int i = 1; i <= 16; i++) begin
      checks++; if (rd_valid !== 1'b1 || rd_data !== DW'(i)) begin
        failures++; $display("FAIL fill_drain got valid=%b data=%0d exp 1 %0d", rd_valid, rd_data, i); end
      do_cycle(2'd0, '0, 1'b1, 1'b0);
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL fill_empty got=%b exp=1", empty); end
    do_cycle(2'd0, '0, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      failures++; $display("FAIL clr_ovf got ovf=%b drop=%0d exp 0 0", overflow, drop_cnt); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 1; i <= 16; i++) do_cycle(2'd1, DW'(i), 1'b0, 1'b0);
    do_cycle(2'd1, DW'(99), 1'b1, 1'b0);
    checks++; if (count !== 5'd16 || overflow !== 1'b0) begin
      failures++; $display("FAIL full_pushpop got count=%0d ovf=%b exp 16 0", count, overflow); end
    for (int i = 2; i <= 17; i++) begin
      checks++; if (rd_data !== ((i == 17) ? DW'(99) : DW'(i))) begin
        failures++; $display("FAIL full_pushpop_drain got=%0d exp=%0d", rd_data, (i == 17) ? 99 : i); end
      do_cycle(2'd0, '0, 1'b1, 1'b0);
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL full_pushpop_empty got=%b exp=1", empty); end
  endtask

  task automatic test_wrap_stream();
    logic [DW-1:0] v;
    for (int i = 0; i < 100; i++) begin
      v = 32'h7FFF_FFF0 + DW'(i);
      do_cycle(2'd1, v, 1'b1, 1'b0);
      checks++; if (rd_valid !== 1'b1 || rd_data !== v || count > 5'd1) begin
        failures++; $display("FAIL wrap_stream i=%0d got data=%h count=%0d exp %h <=1", i, rd_data, count, v); end
    end
    checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      failures++; $display("FAIL wrap_nodrop got ovf=%b drop=%0d exp 0 0", overflow, drop_cnt); end
    do_cycle(2'd0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_drop_clr();
    for (int i = 0; i < 16; i++) do_cycle(2'd1, $urandom, 1'b0, 1'b0);
    do_cycle(2'd1, '1, 1'b0, 1'b0);
    do_cycle(2'd1, '1, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
      failures++; $display("FAIL drop_wins got ovf=%b drop=%0d exp 1 1", overflow, drop_cnt); end
    for (int i = 0; i < 260; i++) do_cycle(2'd1, '0, 1'b0, 1'b0);
    checks++; if (drop_cnt !== 8'd255) begin failures++; $display("FAIL drop_sat got=%0d exp=255", drop_cnt); end
    do_cycle(2'd0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) do_cycle(2'd0, '0, 1'b1, 1'b0);
    checks++; if (empty !== 1'b1 || overflow !== 1'b0) begin
      failures++; $display("FAIL drop_clr_end got empty=%b ovf=%b exp 1 0", empty, overflow); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) do_cycle(2'd1, $urandom, 1'b0, 1'b0);
    checks++; if (count !== 5'd7) begin failures++; $display("FAIL mid_pre_count got=%0d exp=7", count); end
    #2 rst = 1'b1;
    #1;
    checks++; if (count !== 5'd0 || rd_valid !== 1'b0) begin
      failures++; $display("FAIL mid_reset got count=%0d valid=%b exp 0 0", count, rd_valid); end
    #1 rst = 1'b0;
    mq.delete(); mo = 1'b0; md = 0;
    do_cycle(2'd1, DW'(42), 1'b0, 1'b0);
    do_cycle(2'd1, DW'(7), 1'b0, 1'b0);
    checks++; if (rd_data !== DW'(42) || count !== 5'd2) begin
      failures++; $display("FAIL mid_first_word got data=%0d count=%0d exp 42 2", rd_data, count); end
    for (int i = 0; i < 2; i++) do_cycle(2'd0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [1:0] en;
    logic       rdy, clr;
    for (int i = 0; i < 600; i++) begin
      en  = 2'($urandom_range(0, 3));
      rdy = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 31) == 0);
      do_cycle(en, $urandom, rdy, clr);
      checks++; if (count !== 5'(mq.size()) || rd_valid !== (mq.size() > 0) || full !== (mq.size() == DEPTH)) begin
        failures++; $display("FAIL rand_count i=%0d got count=%0d valid=%b full=%b exp count=%0d", i, count, rd_valid, full, mq.size()); end
      if (mq.size() > 0) begin
        checks++; if (rd_data !== mq[0]) begin
          failures++; $display("FAIL rand_data i=%0d got=%h exp=%h", i, rd_data, mq[0]); end
      end
      checks++; if (overflow !== mo || drop_cnt !== 8'(md)) begin
        failures++; $display("FAIL rand_ovf i=%0d got ovf=%b drop=%0d exp ovf=%b drop=%0d", i, overflow, drop_cnt, mo, md); end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_strobe_filter();
    test_fill_overflow();
    test_full_push_pop();
    test_wrap_stream();
    test_drop_clr();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
